and4_bist: RTL and testbench
============================

# and4_bist

Self-test sequencer for the 4-input AND cell `and4`. It drives the cell's inputs A..D through all 16 two-state combinations, waits a programmable settle time for each one, samples the output X, and compares it with the expected value `A&B&C&D`. It accumulates a saturating mismatch count, records the first failing combination, and reports a pass/fail verdict. The block sits beside each `and4` instance under test in the bring-up/diagnostic wrapper.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles each combination is driven before X is sampled. Legal range is 1..255.
- `ERR_W`, default 5: width of the mismatch counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE only.
- `abort`  in  1  cancels a run in progress.
- `dut_x`  in  1  `and4` output X.
- `dut_a`, `dut_b`, `dut_c`, `dut_d`  out  1 each  `and4` inputs A..D.
- `busy`  out  1  high while a run is active.
- `done`  out  1  single-cycle pulse when a run completes.
- `pass`  out  1  verdict of the last completed run.
- `err_cnt`  out  `ERR_W`  number of mismatches; saturates.
- `first_fail`  out  4  combination `{A,B,C,D}` of the first mismatch.

## Operation
- The clock is `clk`. Reset is synchronous and active-low on `rst_n`, and fixed as such.
- Reset values: state IDLE; all outputs 0.
- Drive mapping: `{dut_a,dut_b,dut_c,dut_d}` = 4-bit `combo` register, with `dut_a` as the MSB. Drivers are 4'b0000 in IDLE and DONE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, when `start`=1:
  - Set `combo` to 0, `settle_cnt` to 0, `err_cnt` to 0, `first_fail` to 0, `pass` to 0.
  - Go to SETTLE.
- SETTLE: increment `settle_cnt`. When `settle_cnt` = `SETTLE_CYCLES`-1, go to SAMPLE.
- SAMPLE:
  - Mismatch is `dut_x != &combo`. In simulation, X/Z on `dut_x` counts as a mismatch (4-state compare `!==`).
  - On mismatch:
    - `err_cnt` increments and saturates at 2^ERR_W-1.
    - If `err_cnt` was 0 before this sample, `first_fail` is loaded with `combo`.
  - If `combo`=15, go to DONE.
  - Otherwise `combo` increments, `settle_cnt` clears, and the FSM returns to SETTLE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `pass` is loaded with 1 only if the final mismatch total, including the last sample, is 0.
  - Next state is IDLE.
- `busy` = 1 exactly in SETTLE and SAMPLE.
- `err_cnt`, `first_fail` and `pass` hold their values in IDLE until the next accepted `start`.
- `start` in SETTLE, SAMPLE or DONE is ignored. It is not queued.
- `abort`=1 in SETTLE or SAMPLE:
  - Next state is IDLE; no `done` pulse; `pass` stays 0.
  - `err_cnt` and `first_fail` hold their partial results.
  - `abort` overrides the SAMPLE compare in the same cycle: that sample is discarded.
  - `abort` in IDLE or DONE has no effect.
- Reset asserted mid-run returns the block to reset values on the next edge. No `done` pulse is generated.

## Timing
- The edge that accepts `start` is edge 0. Combination 0 is on the drivers from cycle 1.
- Each combination is held for `SETTLE_CYCLES`+1 cycles: S SETTLE cycles, then 1 SAMPLE cycle. `dut_x` is compared at the closing edge of the SAMPLE cycle.
- Combination k occupies cycles k·(S+1)+1 through (k+1)·(S+1).
- `busy` is high for 16·(S+1) cycles. `done` is high in cycle 16·(S+1)+1; `busy` is 0 in that cycle.
- With S=1:
  - `busy` covers cycles 1..32 and `done` is at cycle 33.
  - `pass`, `err_cnt` and `first_fail` are final and valid from cycle 33.
- The earliest re-`start` is accepted at the edge ending cycle 34 (IDLE).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Ideal AND model, S=1, `start` pulse:
  - drivers step through 0..15 in order, each held 2 cycles;
  - `busy` high for cycles 1..32; `done` pulses at cycle 33;
  - `pass`=1, `err_cnt`=0, `first_fail`=0.
- Model with X stuck at 0: `err_cnt`=1, `first_fail`=4'hF, `pass`=0. Model with X stuck at 1: `err_cnt`=15, `first_fail`=4'h0, `pass`=0.
- Model with X stuck at 1, `ERR_W`=3: `err_cnt` saturates at 7; `first_fail`=0; `done` is still at cycle 33.
- `abort` at cycle 10:
  - `busy`=0 and drivers 0000 at cycle 11; no `done`; `pass`=0;
  - a following `start` runs a clean full sequence with `err_cnt` cleared and ends with `pass`=1.
- Disruption cases:
  - `start` pulses at cycles 5 and 33 are ignored, and `done` occurs exactly once, at cycle 33;
  - `rst_n`=0 at cycle 12 gives all outputs 0 and IDLE on the next edge.
- Model whose X lags its inputs by 2 cycles:
  - with S=3: `pass`=1 and `done` at cycle 65;
  - with S=1: `pass`=0 and `err_cnt`>0.

Source files
------------

// File: rtl/and4_bist.sv
// and4_bist: exhaustive self-test sequencer for a 4-input AND cell
module and4_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_x,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  output logic             dut_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] combo_q, combo_d;
  logic [7:0] settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0] ff_q, ff_d;
  logic pass_q, pass_d;
  logic miss;
  assign miss = dut_x !== &combo_q;
  always_comb begin
    state_d = state_q;
    combo_d = combo_q;
    settle_d = settle_q;
    err_d = err_q;
    ff_d = ff_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        combo_d = '0;
        settle_d = '0;
        err_d = '0;
        ff_d = '0;
        pass_d = 1'b0;
      end
      SETTLE: begin
        settle_d = settle_q + 8'd1;
        state_d = abort ? IDLE : settle_q == 8'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
      end
      SAMPLE: if (abort) state_d = IDLE;
      else begin
        if (miss) begin
          err_d = &err_q ? err_q : err_q + ERR_W'(1);
          if (err_q == '0) ff_d = combo_q;
        end
        if (combo_q == 4'hF) begin
          state_d = DONE;
          pass_d = err_q == '0 && !miss;
        end else begin
          state_d = SETTLE;
          combo_d = combo_q + 4'd1;
          settle_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      combo_q <= '0;
      settle_q <= '0;
      err_q <= '0;
      ff_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      combo_q <= combo_d;
      settle_q <= settle_d;
      err_q <= err_d;
      ff_q <= ff_d;
      pass_q <= pass_d;
    end
  end
  assign busy = state_q == SETTLE || state_q == SAMPLE;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_cnt = err_q;
  assign first_fail = ff_q;
  assign {dut_a, dut_b, dut_c, dut_d} = busy ? combo_q : 4'b0000;
endmodule

// File: tb/tb_and4_bist.sv
// tb_and4_bist: scoreboard bench over three parameterisations driven by fault-mask and lagging AND models
module tb_and4_bist;
  logic clk = 1'b0;
  logic rst_n, start, abort, lag_mode;
  logic [15:0] mask;
  logic [2:0] x_w, busy_w, done_w, pass_w, l1, l2;
  logic [2:0][3:0] drv_w, ff_w;
  logic [4:0] err0, err2;
  logic [2:0] err1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int bc [3];
  typedef struct {
    bit pass;
    int err;
    int ff;
    int dcyc;
  } exp_t;
  exp_t sbq [3][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  and4_bist #(.SETTLE_CYCLES(1), .ERR_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_x(x_w[0]),
    .dut_a(drv_w[0][3]), .dut_b(drv_w[0][2]), .dut_c(drv_w[0][1]), .dut_d(drv_w[0][0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err0), .first_fail(ff_w[0])
  );
  and4_bist #(.SETTLE_CYCLES(1), .ERR_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_x(x_w[1]),
    .dut_a(drv_w[1][3]), .dut_b(drv_w[1][2]), .dut_c(drv_w[1][1]), .dut_d(drv_w[1][0]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err1), .first_fail(ff_w[1])
  );
  and4_bist #(.SETTLE_CYCLES(3), .ERR_W(5)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_x(x_w[2]),
    .dut_a(drv_w[2][3]), .dut_b(drv_w[2][2]), .dut_c(drv_w[2][1]), .dut_d(drv_w[2][0]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err2), .first_fail(ff_w[2])
  );
  always @(posedge clk) begin
    l1 <= {&drv_w[2], &drv_w[1], &drv_w[0]};
    l2 <= l1;
  end
  always_comb begin
    x_w = '0;
    for (int i = 0; i < 3; i++) x_w[i] = lag_mode ? l2[i] : (&drv_w[i]) ^ mask[drv_w[i]];
  end
  function automatic int sp(input int i);
    return i == 2 ? 3 : 1;
  endfunction
  function automatic int ep(input int i);
    return i == 1 ? 3 : 5;
  endfunction
  function automatic int errv(input int i);
    return i == 0 ? int'(err0) : i == 1 ? int'(err1) : int'(err2);
  endfunction
  function automatic exp_t model(input logic [15:0] m, input bit lag, input int i, input int n);
    exp_t r;
    int s, e, f, c, seen;
    s = sp(i);
    e = 0;
    f = 0;
    for (int k = 0; k < n; k++) begin
      bit bad;
      c = (k + 1) * (s + 1) - 2;
      seen = c < 1 ? 0 : (c - 1) / (s + 1);
      bad = lag ? ((seen == 15) != (k == 15)) : m[k];
      if (bad) begin
        if (e == 0) f = k;
        e++;
      end
    end
    r.err = e > (1 << ep(i)) - 1 ? (1 << ep(i)) - 1 : e;
    r.ff = f;
    r.pass = n == 16 && e == 0;
    r.dcyc = 0;
    return r;
  endfunction
  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0d want %0d at cyc %0d", nm, i, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_w[i]) begin
        chk("drivers", i, int'(drv_w[i]), bc[i] / (sp(i) + 1));
        bc[i]++;
      end else begin
        chk("idle_drivers", i, int'(drv_w[i]), 0);
        if (done_w[i]) begin
          if (sbq[i].size() == 0) chk("spurious_done", i, 1, 0);
          else begin
            exp_t e;
            e = sbq[i].pop_front();
            chk("done_cycle", i, cyc, e.dcyc);
            chk("busy_len", i, bc[i], 16 * (sp(i) + 1));
            chk("pass", i, int'(pass_w[i]), int'(e.pass));
            chk("err_cnt", i, errv(i), e.err);
            chk("first_fail", i, int'(ff_w[i]), e.ff);
          end
        end
        bc[i] = 0;
      end
    end
  end
  task automatic chk_zero(input string nm, input int i);
    chk({nm, "_busy"}, i, int'(busy_w[i]), 0);
    chk({nm, "_done"}, i, int'(done_w[i]), 0);
    chk({nm, "_pass"}, i, int'(pass_w[i]), 0);
    chk({nm, "_drv"}, i, int'(drv_w[i]), 0);
  endtask
  task automatic run(input bit lag, input logic [15:0] m, input int ab, input int rc, input bit extra);
    int t1;
    exp_t e;
    lag_mode = lag;
    mask = m;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t1 = cyc;
    if (ab == 0 && rc == 0)
      for (int i = 0; i < 3; i++) begin
        e = model(m, lag, i, 16);
        e.dcyc = t1 + 16 * (sp(i) + 1);
        sbq[i].push_back(e);
      end
    for (int k = 2; k <= 70; k++) begin
      @(negedge clk);
      start = extra && (k == 5 || k == 33);
      abort = k == ab;
      rst_n = !(k == rc);
      if (ab != 0 && k == ab + 1)
        for (int i = 0; i < 3; i++) begin
          e = model(m, lag, i, (ab - 1) / (sp(i) + 1));
          chk_zero("abort", i);
          chk("abort_err", i, errv(i), e.err);
          chk("abort_ff", i, int'(ff_w[i]), e.ff);
        end
      if (rc != 0 && k == rc + 1)
        for (int i = 0; i < 3; i++) begin
          chk_zero("rst", i);
          chk("rst_err", i, errv(i), 0);
          chk("rst_ff", i, int'(ff_w[i]), 0);
        end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    lag_mode = 1'b0;
    mask = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_zero("reset", i);
      chk("reset_err", i, errv(i), 0);
      chk("reset_ff", i, int'(ff_w[i]), 0);
    end
    rst_n = 1'b1;
    run(1'b0, 16'h0000, 0, 0, 1'b0);
    run(1'b0, 16'h8000, 0, 0, 1'b0);
    run(1'b0, 16'h7FFF, 0, 0, 1'b0);
    run(1'b0, 16'($urandom) | 16'h0001, 10, 0, 1'b0);
    run(1'b0, 16'h0000, 0, 0, 1'b0);
    run(1'b0, 16'($urandom), 0, 0, 1'b1);
    run(1'b0, 16'($urandom) | 16'h0003, 0, 12, 1'b0);
    run(1'b1, 16'h0000, 0, 0, 1'b0);
    for (int r = 0; r < 8; r++) run(1'b0, 16'($urandom & $urandom), 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("missing_done", i, sbq[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
